// File: rtl/vm_change_pkg.sv
// Shared types and constants for the change dispenser: FSM states, coin values,
// one-hot hopper eject codes and the inventory counter width.
package vm_change_pkg;

  localparam int INV_W = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_EJECT  = 3'd2,
    S_GAP    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [3:0] COIN_5 = 4'd5;
  localparam logic [3:0] COIN_2 = 4'd2;
  localparam logic [3:0] COIN_1 = 4'd1;

  localparam logic [2:0] EJ_NONE = 3'b000;
  localparam logic [2:0] EJ_5    = 3'b100;
  localparam logic [2:0] EJ_2    = 3'b010;
  localparam logic [2:0] EJ_1    = 3'b001;

endpackage

// File: rtl/coin_select.sv
// Combinational greedy picker: largest coin not above the remaining amount
// whose hopper still holds at least one coin.
module coin_select
  import vm_change_pkg::*;
(
  input  logic [3:0]       i_remaining,
  input  logic [INV_W-1:0] i_inv_5,
  input  logic [INV_W-1:0] i_inv_2,
  input  logic [INV_W-1:0] i_inv_1,
  output logic             o_found,
  output logic [3:0]       o_value,
  output logic [2:0]       o_eject
);

  always_comb begin
    o_found = 1'b0;
    o_value = 4'd0;
    o_eject = EJ_NONE;
    if (i_remaining >= COIN_5 && i_inv_5 != '0) begin
      o_found = 1'b1;
      o_value = COIN_5;
      o_eject = EJ_5;
    end else if (i_remaining >= COIN_2 && i_inv_2 != '0) begin
      o_found = 1'b1;
      o_value = COIN_2;
      o_eject = EJ_2;
    end else if (i_remaining >= COIN_1 && i_inv_1 != '0) begin
      o_found = 1'b1;
      o_value = COIN_1;
      o_eject = EJ_1;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Change-return engine: greedy 5/2/1 breakdown with timed one-hot hopper pulses.
// Define CHANGE_INV_TRACK_EN to enable hopper inventory tracking, refill and shortfall.
//
// state    | meaning
// ---------+--------------------------------------------------
// S_IDLE   | ready for a request; refill applies immediately
// S_SELECT | pick next coin for the remaining amount
// S_EJECT  | eject pulse held for PULSE_CYCLES
// S_GAP    | quiet time of GAP_CYCLES between pulses
// S_DONE   | one-cycle completion, shortfall/alarm published
module change_dispenser
  import vm_change_pkg::*;
#(
  parameter int               PULSE_CYCLES = 4,
  parameter int               GAP_CYCLES   = 2,
  parameter logic [INV_W-1:0] INV_INIT     = 8'd20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             change_valid,
  input  logic [3:0]       change_amount,
  output logic             change_ready,
  input  logic             refill,
  output logic [2:0]       coin_eject,
  output logic             busy,
  output logic             done,
  output logic [3:0]       shortfall,
  output logic             alarm,
  output logic [INV_W-1:0] inv_5,
  output logic [INV_W-1:0] inv_2,
  output logic [INV_W-1:0] inv_1
);

  localparam int CNT_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_remaining;
  logic [3:0]       r_coin_val;
  logic [2:0]       r_coin_oh;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_eject;
  logic             r_busy;
  logic             r_ready;
  logic             r_done;
  logic [3:0]       r_shortfall;
  logic             r_alarm;

  logic [2:0]       w_eject_nxt;
  logic             w_cnt_tc;
  logic             w_sel_found;
  logic [3:0]       w_sel_value;
  logic [2:0]       w_sel_eject;
  logic [3:0]       w_short_nxt;
  logic [INV_W-1:0] w_sel_inv_5;
  logic [INV_W-1:0] w_sel_inv_2;
  logic [INV_W-1:0] w_sel_inv_1;

  assign w_cnt_tc = (r_cnt == '0);

  coin_select u_coin_select (
    .i_remaining (r_remaining),
    .i_inv_5     (w_sel_inv_5),
    .i_inv_2     (w_sel_inv_2),
    .i_inv_1     (w_sel_inv_1),
    .o_found     (w_sel_found),
    .o_value     (w_sel_value),
    .o_eject     (w_sel_eject)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (change_valid) w_state_nxt = S_SELECT;
      S_SELECT: w_state_nxt = w_sel_found ? S_EJECT : S_DONE;
      S_EJECT:  if (w_cnt_tc) w_state_nxt = S_GAP;
      S_GAP:    if (w_cnt_tc) w_state_nxt = S_SELECT;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Eject is registered from the next state so the pulse edges align with state changes.
  always_comb begin
    w_eject_nxt = EJ_NONE;
    if (w_state_nxt == S_EJECT) begin
      w_eject_nxt = (r_state == S_SELECT) ? w_sel_eject : r_coin_oh;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_remaining <= 4'd0;
      r_coin_val  <= 4'd0;
      r_coin_oh   <= EJ_NONE;
      r_cnt       <= '0;
      r_eject     <= EJ_NONE;
      r_busy      <= 1'b0;
      r_ready     <= 1'b1;
      r_done      <= 1'b0;
      r_shortfall <= 4'd0;
      r_alarm     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_eject <= w_eject_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_ready <= (w_state_nxt == S_IDLE);
      r_done  <= (w_state_nxt == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (change_valid) begin
            r_remaining <= change_amount;
            r_shortfall <= 4'd0;
            r_alarm     <= 1'b0;
          end
        end
        S_SELECT: begin
          if (w_sel_found) begin
            r_coin_val <= w_sel_value;
            r_coin_oh  <= w_sel_eject;
            r_cnt      <= PULSE_LD;
          end else begin
            r_shortfall <= w_short_nxt;
            r_alarm     <= (w_short_nxt != 4'd0);
          end
        end
        S_EJECT: begin
          if (w_cnt_tc) begin
            r_remaining <= r_remaining - r_coin_val;
            r_cnt       <= GAP_LD;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        S_GAP: begin
          if (!w_cnt_tc) r_cnt <= r_cnt - CNT_ONE;
        end
        default: ;
      endcase
    end
  end

`ifdef CHANGE_INV_TRACK_EN
  localparam logic [INV_W-1:0] INV_ONE = INV_W'(1);

  logic [INV_W-1:0] r_inv_5;
  logic [INV_W-1:0] r_inv_2;
  logic [INV_W-1:0] r_inv_1;
  logic             r_refill_pend;
  logic             w_eject_last;
  logic             w_reload;

  assign w_eject_last = (r_state == S_EJECT) && w_cnt_tc;
  // Refills seen while busy are held and folded into one reload on the way back to IDLE.
  assign w_reload     = ((r_state == S_IDLE) && refill) ||
                        ((r_state == S_DONE) && (r_refill_pend || refill));
  assign w_short_nxt  = r_remaining;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_inv_5       <= INV_INIT;
      r_inv_2       <= INV_INIT;
      r_inv_1       <= INV_INIT;
      r_refill_pend <= 1'b0;
    end else if (w_reload) begin
      r_inv_5       <= INV_INIT;
      r_inv_2       <= INV_INIT;
      r_inv_1       <= INV_INIT;
      r_refill_pend <= 1'b0;
    end else begin
      if (refill && r_state != S_IDLE) r_refill_pend <= 1'b1;
      if (w_eject_last) begin
        case (r_coin_oh)
          EJ_5:    r_inv_5 <= r_inv_5 - INV_ONE;
          EJ_2:    r_inv_2 <= r_inv_2 - INV_ONE;
          EJ_1:    r_inv_1 <= r_inv_1 - INV_ONE;
          default: ;
        endcase
      end
    end
  end

  assign w_sel_inv_5 = r_inv_5;
  assign w_sel_inv_2 = r_inv_2;
  assign w_sel_inv_1 = r_inv_1;
  assign inv_5       = r_inv_5;
  assign inv_2       = r_inv_2;
  assign inv_1       = r_inv_1;
`else
  // Hoppers treated as bottomless: the picker sees a nonzero stock on every hopper.
  localparam logic [INV_W-1:0] INV_ANY = INV_W'(1);

  logic w_unused_refill;

  assign w_unused_refill = refill;
  assign w_short_nxt     = 4'd0;
  assign w_sel_inv_5     = INV_ANY;
  assign w_sel_inv_2     = INV_ANY;
  assign w_sel_inv_1     = INV_ANY;
  assign inv_5           = INV_INIT;
  assign inv_2           = INV_INIT;
  assign inv_1           = INV_INIT;
`endif

  assign change_ready = r_ready;
  assign coin_eject   = r_eject;
  assign busy         = r_busy;
  assign done         = r_done;
  assign shortfall    = r_shortfall;
  assign alarm        = r_alarm;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser; expectations follow CHANGE_INV_TRACK_EN
// when that macro is defined for the build.
module tb_change_dispenser;

  localparam int PULSE = 4;
  localparam int STEP  = 1 + PULSE + 2;

  logic       clk;
  logic       reset;
  logic       change_valid;
  logic [3:0] change_amount;
  logic       change_ready;
  logic       refill;
  logic [2:0] coin_eject;
  logic       busy;
  logic       done;
  logic [3:0] shortfall;
  logic       alarm;
  logic [7:0] inv_5;
  logic [7:0] inv_2;
  logic [7:0] inv_1;

  int n_tests = 0;
  int n_fail  = 0;

  int         p_cnt;
  int         p_start [8];
  logic [2:0] p_code  [8];
  int         p_len   [8];
  int         done_cyc;
  int         glitch;
  int         multi;
  logic [3:0] sf;
  logic       al;
  logic       alarm_c1;

  change_dispenser #(
    .PULSE_CYCLES (4),
    .GAP_CYCLES   (2),
    .INV_INIT     (8'd20)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .change_valid  (change_valid),
    .change_amount (change_amount),
    .change_ready  (change_ready),
    .refill        (refill),
    .coin_eject    (coin_eject),
    .busy          (busy),
    .done          (done),
    .shortfall     (shortfall),
    .alarm         (alarm),
    .inv_5         (inv_5),
    .inv_2         (inv_2),
    .inv_1         (inv_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One request: accept, then sample every cycle at the falling edge until done.
  // Cycle 1 is the first cycle after the accepting edge.
  task automatic run_req(input logic [3:0] amt, input int refill_at);
    logic [2:0] e;
    logic [2:0] prev;
    int         cyc;
    bit         fin;
    p_cnt = 0; glitch = 0; multi = 0; done_cyc = -1; prev = 3'b000; fin = 0;
    @(negedge clk);
    change_amount = amt;
    change_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    change_valid = 1'b0;
    cyc = 1;
    while (!fin && cyc <= 300) begin
      e = coin_eject;
      if (cyc == 1) alarm_c1 = alarm;
      if ($countones(e) > 1) multi++;
      if (e != 3'b000 && prev == 3'b000) begin
        if (p_cnt < 8) begin
          p_start[p_cnt] = cyc;
          p_code[p_cnt]  = e;
          p_len[p_cnt]   = 1;
        end
        p_cnt++;
      end else if (e != 3'b000 && e == prev) begin
        if (p_cnt >= 1 && p_cnt <= 8) p_len[p_cnt-1]++;
      end else if (e != 3'b000) begin
        glitch++;
      end
      prev = e;
      if (done) begin
        done_cyc = cyc;
        sf       = shortfall;
        al       = alarm;
        fin      = 1;
      end else begin
        refill = (cyc == refill_at);
        @(negedge clk);
        cyc++;
      end
    end
    refill = 1'b0;
    check_eq("req_done", fin, 1);
  endtask

  task automatic expect_pulses(input string tag, input int n, input logic [2:0] c0,
                               input logic [2:0] c1, input logic [2:0] c2,
                               input logic [2:0] c3, input logic [2:0] c4, input int dcyc);
    logic [2:0] ec [5];
    ec = '{c0, c1, c2, c3, c4};
    check_eq({tag, ".npulse"}, p_cnt, n);
    for (int i = 0; i < n && i < 5 && i < p_cnt; i++) begin
      check_eq({tag, ".code"}, p_code[i], ec[i]);
      check_eq({tag, ".start"}, p_start[i], 2 + i * STEP);
      check_eq({tag, ".len"}, p_len[i], PULSE);
    end
    check_eq({tag, ".done_cyc"}, done_cyc, dcyc);
    check_eq({tag, ".glitch"}, glitch, 0);
    check_eq({tag, ".onehot"}, multi, 0);
  endtask

  task automatic idle_refill();
    @(negedge clk);
    refill = 1'b1;
    @(negedge clk);
    refill = 1'b0;
  endtask

  initial begin
    reset = 1'b1; change_valid = 1'b0; change_amount = 4'd0; refill = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst.ready", change_ready, 1);
    check_eq("rst.busy", busy, 0);
    check_eq("rst.eject", coin_eject, 0);
    check_eq("rst.done", done, 0);
    check_eq("rst.short", shortfall, 0);
    check_eq("rst.alarm", alarm, 0);
    check_eq("rst.inv5", inv_5, 20);
    check_eq("rst.inv1", inv_1, 20);
    reset = 1'b0;

    // 8 -> 5,2,1
    run_req(4'd8, -1);
    expect_pulses("amt8", 3, 3'b100, 3'b010, 3'b001, 3'b000, 3'b000, 23);
    check_eq("amt8.short", sf, 0);
    check_eq("amt8.alarm", al, 0);
`ifdef CHANGE_INV_TRACK_EN
    check_eq("amt8.inv5", inv_5, 19);
    check_eq("amt8.inv2", inv_2, 19);
    check_eq("amt8.inv1", inv_1, 19);
`else
    check_eq("amt8.inv5", inv_5, 20);
    check_eq("amt8.inv2", inv_2, 20);
`endif
    @(negedge clk);
    check_eq("amt8.ready_after", change_ready, 1);
    check_eq("amt8.busy_after", busy, 0);

    idle_refill();
    check_eq("refill_idle.inv5", inv_5, 20);
    check_eq("refill_idle.inv1", inv_1, 20);

    run_req(4'd0, -1);
    expect_pulses("amt0", 0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 2);
    check_eq("amt0.short", sf, 0);
    check_eq("amt0.alarm", al, 0);

    run_req(4'd15, -1);
    expect_pulses("amt15", 3, 3'b100, 3'b100, 3'b100, 3'b000, 3'b000, 23);
`ifdef CHANGE_INV_TRACK_EN
    check_eq("amt15.inv5", inv_5, 17);
    idle_refill();
`endif

    // refill during first EJECT is deferred to the return to IDLE
    run_req(4'd8, 3);
    expect_pulses("rfl_busy", 3, 3'b100, 3'b010, 3'b001, 3'b000, 3'b000, 23);
`ifdef CHANGE_INV_TRACK_EN
    check_eq("rfl_busy.inv5_done", inv_5, 19);
    check_eq("rfl_busy.inv2_done", inv_2, 19);
    check_eq("rfl_busy.inv1_done", inv_1, 19);
`endif
    @(negedge clk);
    check_eq("rfl_busy.inv5_idle", inv_5, 20);
    check_eq("rfl_busy.inv2_idle", inv_2, 20);
    check_eq("rfl_busy.inv1_idle", inv_1, 20);

`ifdef CHANGE_INV_TRACK_EN
    for (int k = 0; k < 6; k++) run_req(4'd15, -1);
    run_req(4'd10, -1);
    check_eq("drain5.inv5", inv_5, 0);
    run_req(4'd10, -1);
    expect_pulses("no5_amt10", 5, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 37);
    check_eq("no5_amt10.inv2", inv_2, 15);
    check_eq("no5_amt10.short", sf, 0);
    check_eq("no5_amt10.alarm", al, 0);
    idle_refill();
    for (int k = 0; k < 6; k++) run_req(4'd15, -1);
    run_req(4'd5, -1);
    for (int k = 0; k < 10; k++) run_req(4'd4, -1);
    for (int k = 0; k < 5; k++) run_req(4'd4, -1);
    check_eq("drain.inv5", inv_5, 1);
    check_eq("drain.inv2", inv_2, 0);
    check_eq("drain.inv1", inv_1, 0);
    run_req(4'd7, -1);
    expect_pulses("short7", 1, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000, 9);
    check_eq("short7.short", sf, 2);
    check_eq("short7.alarm", al, 1);
    @(negedge clk);
    check_eq("short7.alarm_sticky", alarm, 1);
    check_eq("short7.short_hold", shortfall, 2);
`else
    run_req(4'd10, -1);
    expect_pulses("amt10", 2, 3'b100, 3'b100, 3'b000, 3'b000, 3'b000, 16);
    check_eq("amt10.inv2", inv_2, 20);
    check_eq("amt10.short", sf, 0);
    run_req(4'd7, -1);
    expect_pulses("amt7", 2, 3'b100, 3'b010, 3'b000, 3'b000, 3'b000, 16);
    check_eq("amt7.short", sf, 0);
    check_eq("amt7.alarm", al, 0);
`endif
    run_req(4'd0, -1);
    check_eq("next.alarm_clr", alarm_c1, 0);
    check_eq("next.short", sf, 0);
    check_eq("next.done_cyc", done_cyc, 2);

    // reset in the middle of an eject pulse
    @(negedge clk);
    change_amount = 4'd8;
    change_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    change_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rstmid.ejecting", coin_eject, 3'b100);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rstmid.eject", coin_eject, 0);
    check_eq("rstmid.busy", busy, 0);
    check_eq("rstmid.ready", change_ready, 1);
    check_eq("rstmid.inv5", inv_5, 20);
    check_eq("rstmid.inv2", inv_2, 20);
    @(negedge clk);
    reset = 1'b0;
    run_req(4'd3, -1);
    expect_pulses("post_rst", 2, 3'b010, 3'b001, 3'b000, 3'b000, 3'b000, 16);
    check_eq("post_rst.short", sf, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
